proc_multiciclo_param: RTL and testbench

//  Parametrised multicycle 16-bit-ISA processor core: FETCH/DECODE/EXEC/WB FSM, internal 16-entry register file, ALU, branch/jump unit.

---
 rtl/proc_multiciclo_param.sv | 220 ++++++++++++++++++++++
 tb/tb_proc_multiciclo_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_multiciclo_param.sv
// rtl/proc_multiciclo_param.sv - parametrised multicycle 16-bit-ISA processor core
//
// Purpose: FETCH/DECODE/EXEC/WB processor with a 16-entry register file, an ALU and a
// branch/jump unit. Instruction memory is external behind a req/ack handshake, so
// wait-state ROMs can be attached. step_en freezes the whole core for single-stepping.
//
// Ports:
//   CLOCK_50    in   1    system clock, rising edge
//   reset       in   1    asynchronous, active-low
//   step_en     in   1    1 = FSM advances, 0 = everything holds
//   imem_req    out  1    fetch request (high for the whole FETCH state)
//   imem_addr   out  PCW  fetch address (= PC)
//   imem_ack    in   1    fetch done, imem_rdata valid this cycle
//   imem_rdata  in   16   instruction word
//   wb_en       out  1    register write happens this cycle
//   wb_addr     out  4    destination register
//   wb_data     out  DW   value being written
//   retire      out  1    one pulse per completed instruction
//   pc_dbg      out  PCW  current PC
//   halted      out  1    core stopped by HALT
module proc_multiciclo_param #(
  parameter int DW  = 16,
  parameter int PCW = 12
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           step_en,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [15:0]    imem_rdata,
  output logic           wb_en,
  output logic [3:0]     wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic           retire,
  output logic [PCW-1:0] pc_dbg,
  output logic           halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_SHLI = 4'd8;
  localparam logic [3:0] OP_SHRI = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t         r_state;
  state_t         w_next;
  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] r_npc;
  logic [15:0]    r_ir;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [DW-1:0]  r_alu;
  logic [DW-1:0]  r_rf [16];

  logic [3:0]     w_op;
  logic [3:0]     w_rc;
  logic [3:0]     w_ra;
  logic [3:0]     w_rb;
  logic [3:0]     w_a_sel;
  logic [3:0]     w_b_sel;
  logic [DW-1:0]  w_rd_a;
  logic [DW-1:0]  w_rd_b;
  logic [DW-1:0]  w_imm4;
  logic [DW-1:0]  w_imm8;
  logic [DW-1:0]  w_lo_mask;
  logic [DW-1:0]  w_alu;
  logic [PCW-1:0] w_pc_inc;
  logic [PCW-1:0] w_br_off;
  logic [PCW-1:0] w_npc;
  logic           w_wr_op;
  logic           w_wb;

  // Instruction fields
  assign w_op = r_ir[15:12];
  assign w_rc = r_ir[11:8];
  assign w_ra = r_ir[7:4];
  assign w_rb = r_ir[3:0];

  // Immediate ops take their source from rb; BEQ compares rc with ra and LDI
  // needs the old rc value to keep its upper bits.
  assign w_a_sel = (w_op >= OP_ADDI && w_op <= OP_SHRI) ? w_rb : w_ra;
  assign w_b_sel = (w_op == OP_LDI || w_op == OP_BEQ) ? w_rc : w_rb;

  // R0 is hardwired to zero on the read side
  assign w_rd_a = (w_a_sel == 4'd0) ? '0 : r_rf[w_a_sel];
  assign w_rd_b = (w_b_sel == 4'd0) ? '0 : r_rf[w_b_sel];

  assign w_imm4    = DW'(r_ir[7:4]);
  assign w_imm8    = DW'(r_ir[7:0]);
  assign w_lo_mask = DW'(8'hFF);

  // ALU
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLT:  w_alu = DW'($signed(r_a) < $signed(r_b));
      OP_ADDI: w_alu = r_a + w_imm4;
      OP_SUBI: w_alu = r_a - w_imm4;
      OP_SHLI: w_alu = r_a << r_ir[7:4];
      OP_SHRI: w_alu = r_a >> r_ir[7:4];
      OP_LDI:  w_alu = (r_b & ~w_lo_mask) | w_imm8;
      default: w_alu = '0;
    endcase
  end

  // Branch/jump unit; all PC arithmetic wraps at 2^PCW
  assign w_pc_inc = r_pc + PCW'(1);
  assign w_br_off = PCW'($signed(r_ir[3:0]));

  always_comb begin
    w_npc = w_pc_inc;
    if (w_op == OP_JMP) begin
      w_npc = PCW'(r_ir[11:0]);
    end else if (w_op == OP_BEQ && r_a == r_b) begin
      w_npc = w_pc_inc + w_br_off;
    end
  end

  // Ops 0..10 write rc, except that R0 is never written
  assign w_wr_op = (w_op <= OP_LDI);
  assign w_wb    = (r_state == S_WB) && w_wr_op && (w_rc != 4'd0);

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_npc   <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= '0;
      end
    end else if (step_en) begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
          end
        end
        S_DECODE: begin
          r_a <= w_rd_a;
          r_b <= w_rd_b;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          r_npc <= w_npc;
        end
        S_WB: begin
          r_pc <= r_npc;
          if (w_wb) begin
            r_rf[w_rc] <= r_alu;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    imem_addr = r_pc;
    wb_en     = 1'b0;
    wb_addr   = 4'd0;
    wb_data   = '0;
    retire    = 1'b0;
    pc_dbg    = r_pc;
    halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next = (w_op == OP_HALT) ? S_HALT : S_WB;
      end
      S_WB: begin
        w_next  = S_FETCH;
        retire  = 1'b1;
        wb_en   = w_wb;
        wb_addr = w_wb ? w_rc : 4'd0;
        wb_data = w_wb ? r_alu : '0;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_proc_multiciclo_param.sv
// tb/tb_proc_multiciclo_param.sv - directed bench for proc_multiciclo_param
module tb_proc_multiciclo_param;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        step_en  = 1'b1;

  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack   = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        retire;
  logic [11:0] pc_dbg;
  logic        halted;

  logic        imem_req4;
  logic [3:0]  imem_addr4;
  logic        imem_ack4   = 1'b0;
  logic [15:0] imem_rdata4 = 16'h0;
  logic        wb_en4;
  logic [3:0]  wb_addr4;
  logic [15:0] wb_data4;
  logic        retire4;
  logic [3:0]  pc_dbg4;
  logic        halted4;

  logic [15:0] mem  [4096];
  logic [15:0] mem4 [16];
  int          wait_n = 0;
  int          wcnt   = 0;
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ins;
    logic        wb;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [11:0] npc;
  } vec_t;
  vec_t tv[$];

  proc_multiciclo_param #(.DW(16), .PCW(12)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .step_en(step_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retire(retire),
    .pc_dbg(pc_dbg), .halted(halted)
  );

  proc_multiciclo_param #(.DW(16), .PCW(4)) dut4 (
    .CLOCK_50(CLOCK_50), .reset(reset), .step_en(step_en),
    .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_ack(imem_ack4), .imem_rdata(imem_rdata4),
    .wb_en(wb_en4), .wb_addr(wb_addr4), .wb_data(wb_data4), .retire(retire4),
    .pc_dbg(pc_dbg4), .halted(halted4)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Instruction ROM with wait_n wait cycles before each ack
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (imem_req && step_en && !imem_ack) begin
      if (wcnt >= wait_n) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wcnt       = 0;
      end else begin
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      imem_ack4 = 1'b0;
    end else if (imem_req4 && step_en && !imem_ack4) begin
      imem_ack4   = 1'b1;
      imem_rdata4 = mem4[imem_addr4];
    end else begin
      imem_ack4 = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [11:0] pc, input logic [15:0] ins, input logic wb,
                     input logic [3:0] wa, input logic [15:0] wd, input logic [11:0] npc);
    vec_t v;
    v.pc = pc; v.ins = ins; v.wb = wb; v.wa = wa; v.wd = wd; v.npc = npc;
    tv.push_back(v);
    mem[pc] = ins;
  endtask

  task automatic wait_ret(input bit d4, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLOCK_50);
      if (d4 ? retire4 : retire) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL retire_timeout: got no retire, expected one within 60 cycles");
    end
  endtask

  task automatic run_table(input int nv, input int exp_int);
    bit ok;
    int prev;
    prev = 0;
    for (int i = 0; i < nv; i++) begin
      wait_ret(1'b0, ok);
      if (!ok) return;
      chk($sformatf("v%0d pc", i), pc_dbg, tv[i].pc);
      chk($sformatf("v%0d wb_en", i), wb_en, tv[i].wb);
      if (tv[i].wb) begin
        chk($sformatf("v%0d wb_addr", i), wb_addr, tv[i].wa);
        chk($sformatf("v%0d wb_data", i), wb_data, tv[i].wd);
      end
      if (i > 0) chk($sformatf("v%0d cycles", i), cyc - prev, exp_int);
      prev = cyc;
      @(negedge CLOCK_50);
      chk($sformatf("v%0d next_addr", i), imem_addr, tv[i].npc);
      chk($sformatf("v%0d req", i), imem_req, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0;
    mem4[0]  = 16'hC123;
    mem4[3]  = 16'hC00F;
    mem4[15] = 16'hE000;

    //   pc      instr     wb    rd     data       next pc
    add(12'd0,  16'h6150, 1'b1, 4'd1,  16'h0005, 12'd1);
    add(12'd1,  16'h6230, 1'b1, 4'd2,  16'h0003, 12'd2);
    add(12'd2,  16'h0312, 1'b1, 4'd3,  16'h0008, 12'd3);
    add(12'd3,  16'h6090, 1'b0, 4'd0,  16'h0000, 12'd4);
    add(12'd4,  16'h0401, 1'b1, 4'd4,  16'h0005, 12'd5);
    add(12'd5,  16'h6610, 1'b1, 4'd6,  16'h0001, 12'd6);
    add(12'd6,  16'h1506, 1'b1, 4'd5,  16'hFFFF, 12'd7);
    add(12'd7,  16'h5756, 1'b1, 4'd7,  16'h0001, 12'd8);
    add(12'd8,  16'h5865, 1'b1, 4'd8,  16'h0000, 12'd9);
    add(12'd9,  16'h2953, 1'b1, 4'd9,  16'h0008, 12'd10);
    add(12'd10, 16'h3A13, 1'b1, 4'd10, 16'h000D, 12'd11);
    add(12'd11, 16'h4B51, 1'b1, 4'd11, 16'hFFFA, 12'd12);
    add(12'd12, 16'h7C13, 1'b1, 4'd12, 16'h0007, 12'd13);
    add(12'd13, 16'h8D25, 1'b1, 4'd13, 16'hFFFC, 12'd14);
    add(12'd14, 16'h9E45, 1'b1, 4'd14, 16'h0FFF, 12'd15);
    add(12'd15, 16'hA534, 1'b1, 4'd5,  16'hFF34, 12'd16);
    add(12'd16, 16'hB142, 1'b0, 4'd0,  16'h0000, 12'd19);
    add(12'd19, 16'hB122, 1'b0, 4'd0,  16'h0000, 12'd20);
    add(12'd20, 16'hB11C, 1'b0, 4'd0,  16'h0000, 12'd17);
    add(12'd17, 16'hD000, 1'b0, 4'd0,  16'h0000, 12'd18);
    add(12'd18, 16'hC016, 1'b0, 4'd0,  16'h0000, 12'd22);
    add(12'd22, 16'hE000, 1'b0, 4'd0,  16'h0000, 12'd23);
    add(12'd23, 16'hCFFF, 1'b0, 4'd0,  16'h0000, 12'hFFF);
    add(12'hFFF, 16'hE000, 1'b0, 4'd0, 16'h0000, 12'd0);
    add(12'd0,  16'h6150, 1'b1, 4'd1,  16'h0005, 12'd1);
    mem[21] = 16'hF000;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst imem_req", imem_req, 1'b1);
    chk("rst imem_addr", imem_addr, 12'd0);
    chk("rst pc_dbg", pc_dbg, 12'd0);
    chk("rst wb_en", wb_en, 1'b0);
    chk("rst retire", retire, 1'b0);
    chk("rst halted", halted, 1'b0);

    // Full program, zero-wait memory
    @(posedge CLOCK_50); #2 reset = 1'b1;
    run_table(tv.size(), 4);

    // Three wait cycles on every fetch
    @(posedge CLOCK_50); #2 reset = 1'b0;
    wait_n = 3;
    @(posedge CLOCK_50); #2 reset = 1'b1;
    run_table(3, 7);

    // Freeze mid-EXEC, then HALT
    @(posedge CLOCK_50); #2 reset = 1'b0;
    wait_n = 0;
    mem[0] = 16'h6150;
    mem[1] = 16'h0211;
    mem[2] = 16'hF000;
    @(posedge CLOCK_50); #2 reset = 1'b1;
    wait_ret(1'b0, ok);
    chk("t6 first wb_data", wb_data, 16'h0005);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2 step_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("frz%0d outs", k), {imem_req, wb_en, retire, halted}, 4'b0000);
      chk($sformatf("frz%0d pc", k), pc_dbg, 12'd1);
    end
    @(posedge CLOCK_50); #2 step_en = 1'b1;
    wait_ret(1'b0, ok);
    chk("t6 wb_addr", wb_addr, 4'd2);
    chk("t6 wb_data", wb_data, 16'h000A);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (halted) break;
    end
    repeat (3) @(negedge CLOCK_50);
    chk("halt halted", halted, 1'b1);
    chk("halt imem_req", imem_req, 1'b0);
    chk("halt retire", retire, 1'b0);
    chk("halt pc", pc_dbg, 12'd2);

    // Reset asserted during WB
    @(posedge CLOCK_50); #2 reset = 1'b0;
    @(posedge CLOCK_50); #2 reset = 1'b1;
    wait_ret(1'b0, ok);
    #1 reset = 1'b0;
    #1;
    chk("wbrst wb_en", wb_en, 1'b0);
    chk("wbrst retire", retire, 1'b0);
    chk("wbrst pc", pc_dbg, 12'd0);
    chk("wbrst imem_req", imem_req, 1'b1);
    @(posedge CLOCK_50); #2 reset = 1'b1;
    wait_ret(1'b0, ok);
    chk("wbrst restart pc", pc_dbg, 12'd0);
    chk("wbrst restart data", wb_data, 16'h0005);

    // PCW=4 instance: JMP truncation and PC wrap
    @(posedge CLOCK_50); #2 reset = 1'b0;
    @(posedge CLOCK_50); #2 reset = 1'b1;
    wait_ret(1'b1, ok);
    chk("p4 jmp pc", pc_dbg4, 4'd0);
    @(negedge CLOCK_50);
    chk("p4 jmp target", imem_addr4, 4'd3);
    wait_ret(1'b1, ok);
    @(negedge CLOCK_50);
    chk("p4 jmp 15", imem_addr4, 4'd15);
    wait_ret(1'b1, ok);
    chk("p4 nop pc", pc_dbg4, 4'd15);
    @(negedge CLOCK_50);
    chk("p4 wrap", imem_addr4, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
